rom_ctrl_rd_arb: RTL and testbench

//  Owns the single ROM macro read port. Shares it between three requesters: the boot-time

---
 rtl/rom_ctrl_pkg.sv | 19 +
 rtl/rom_ctrl_rd_arb_streak.sv | 20 ++
 rtl/rom_ctrl_rd_arb.sv | 105 ++++++++++
 tb/tb_rom_ctrl_rd_arb.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/rom_ctrl_pkg.sv
// rom_ctrl_pkg: shared encodings for the ROM read-port arbiter
package rom_ctrl_pkg;
  localparam logic [3:0] MuBi4True  = 4'h6;
  localparam logic [3:0] MuBi4False = 4'h9;
  typedef enum logic [5:0] {
    StCheckOwn  = 6'b101100,
    StArbitrate = 6'b010110,
    StInvalid   = 6'b111011
  } rd_arb_state_e;
  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnChk  = 2'd1,
    OwnBus  = 2'd2,
    OwnScr  = 2'd3
  } rd_owner_e;
  function automatic int vbits(int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/rom_ctrl_rd_arb_streak.sv
// rom_ctrl_rd_arb_streak: counts consecutive bus grants while scrub waits; starve_o forces a scrub grant
module rom_ctrl_rd_arb_streak #(
  parameter int MaxBusStreak = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic bus_gnt_i,
  input  logic scr_req_i,
  input  logic scr_gnt_i,
  output logic starve_o
);
  localparam int SW = $clog2(MaxBusStreak + 1);
  logic [SW-1:0] r_streak;
  assign starve_o = (r_streak == SW'(MaxBusStreak));
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_streak <= '0;
    else if (scr_gnt_i || !scr_req_i) r_streak <= '0;
    else if (bus_gnt_i && !starve_o) r_streak <= r_streak + SW'(1);
  end
endmodule

// File: rtl/rom_ctrl_rd_arb.sv
// rom_ctrl_rd_arb: ROM read-port owner/arbiter (checker, bus, scrubber); perf counters under ROM_CTRL_RD_ARB_PERF_EN
module rom_ctrl_rd_arb
  import rom_ctrl_pkg::*;
#(
  parameter int RomDepth     = 16,
  parameter int MaxBusStreak = 8,
  parameter int PerfCntW     = 16,
  localparam int AW          = vbits(RomDepth)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [3:0]          sel_bus_i,
  input  logic                chk_req_i,
  input  logic [AW-1:0]       chk_addr_i,
  output logic                chk_rvalid_o,
  input  logic                bus_req_i,
  input  logic [AW-1:0]       bus_addr_i,
  output logic                bus_gnt_o,
  output logic                bus_rvalid_o,
  input  logic                scr_req_i,
  input  logic [AW-1:0]       scr_addr_i,
  output logic                scr_gnt_o,
  output logic                scr_rvalid_o,
  output logic                rom_req_o,
  output logic [AW-1:0]       rom_addr_o,
  input  logic [31:0]         rom_rdata_i,
  output logic [31:0]         rdata_o,
  output logic [PerfCntW-1:0] perf_stall_o,
  output logic [PerfCntW-1:0] perf_scr_o,
  output logic                alert_o
);
  rd_arb_state_e r_state, w_state_d;
  rd_owner_e     r_owner, w_owner_d;
  logic          w_starve;
  rom_ctrl_rd_arb_streak #(.MaxBusStreak(MaxBusStreak)) u_streak (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .bus_gnt_i (bus_gnt_o),
    .scr_req_i (scr_req_i),
    .scr_gnt_i (scr_gnt_o),
    .starve_o  (w_starve)
  );
  // Unknown state encodings fall through to the alerting branch.
  always_comb begin
    w_state_d  = StInvalid;
    w_owner_d  = OwnNone;
    bus_gnt_o  = 1'b0;
    scr_gnt_o  = 1'b0;
    rom_req_o  = 1'b0;
    rom_addr_o = '0;
    alert_o    = 1'b0;
    if (r_state == StCheckOwn)
      w_state_d = (sel_bus_i == MuBi4True)  ? StArbitrate :
                  (sel_bus_i == MuBi4False) ? StCheckOwn  : StInvalid;
    else if (r_state == StArbitrate)
      w_state_d = (chk_req_i || sel_bus_i != MuBi4True) ? StInvalid : StArbitrate;
    if (rst_ni) begin
      if (r_state == StCheckOwn) begin
        rom_req_o  = chk_req_i;
        rom_addr_o = chk_addr_i;
        w_owner_d  = chk_req_i ? OwnChk : OwnNone;
      end else if (r_state == StArbitrate) begin
        scr_gnt_o  = scr_req_i && (!bus_req_i || w_starve);
        bus_gnt_o  = bus_req_i && !scr_gnt_o;
        rom_req_o  = bus_gnt_o || scr_gnt_o;
        rom_addr_o = scr_gnt_o ? scr_addr_i : bus_gnt_o ? bus_addr_i : '0;
        w_owner_d  = scr_gnt_o ? OwnScr : bus_gnt_o ? OwnBus : OwnNone;
      end else begin
        alert_o = 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= StCheckOwn;
      r_owner <= OwnNone;
    end else begin
      r_state <= w_state_d;
      r_owner <= w_owner_d;
    end
  end
  assign chk_rvalid_o = rst_ni && (r_owner == OwnChk);
  assign bus_rvalid_o = rst_ni && (r_owner == OwnBus);
  assign scr_rvalid_o = rst_ni && (r_owner == OwnScr);
  assign rdata_o      = rom_rdata_i;
`ifdef ROM_CTRL_RD_ARB_PERF_EN
  logic [PerfCntW-1:0] r_perf_stall, r_perf_scr;
  logic                w_stall;
  assign w_stall = (r_state == StArbitrate) && bus_req_i && !bus_gnt_o;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_perf_stall <= '0;
      r_perf_scr   <= '0;
    end else begin
      if (w_stall && !(&r_perf_stall)) r_perf_stall <= r_perf_stall + PerfCntW'(1);
      if (scr_gnt_o && !(&r_perf_scr)) r_perf_scr <= r_perf_scr + PerfCntW'(1);
    end
  end
  assign perf_stall_o = r_perf_stall;
  assign perf_scr_o   = r_perf_scr;
`else
  assign perf_stall_o = '0;
  assign perf_scr_o   = '0;
`endif
endmodule

// File: tb/tb_rom_ctrl_rd_arb.sv
// tb_rom_ctrl_rd_arb: scoreboard bench for the ROM read-port arbiter
module tb_rom_ctrl_rd_arb;
  import rom_ctrl_pkg::*;
`ifdef ROM_CTRL_RD_ARB_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif
  typedef struct packed {
    rd_owner_e  own;
    logic [3:0] addr;
  } sb_t;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [3:0]  sel_bus_i;
  logic        chk_req_i, bus_req_i, scr_req_i;
  logic [3:0]  chk_addr_i, bus_addr_i, scr_addr_i;
  logic        chk_rvalid_o, bus_gnt_o, bus_rvalid_o, scr_gnt_o, scr_rvalid_o;
  logic        rom_req_o, alert_o;
  logic [3:0]  rom_addr_o;
  logic [31:0] rom_rdata_i, rdata_o;
  logic [15:0] perf_stall_o, perf_scr_o;
  int          n_chk = 0;
  int          n_err = 0;
  sb_t         sb[$];
  always #5 clk_i = ~clk_i;
  rom_ctrl_rd_arb dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .sel_bus_i    (sel_bus_i),
    .chk_req_i    (chk_req_i),
    .chk_addr_i   (chk_addr_i),
    .chk_rvalid_o (chk_rvalid_o),
    .bus_req_i    (bus_req_i),
    .bus_addr_i   (bus_addr_i),
    .bus_gnt_o    (bus_gnt_o),
    .bus_rvalid_o (bus_rvalid_o),
    .scr_req_i    (scr_req_i),
    .scr_addr_i   (scr_addr_i),
    .scr_gnt_o    (scr_gnt_o),
    .scr_rvalid_o (scr_rvalid_o),
    .rom_req_o    (rom_req_o),
    .rom_addr_o   (rom_addr_o),
    .rom_rdata_i  (rom_rdata_i),
    .rdata_o      (rdata_o),
    .perf_stall_o (perf_stall_o),
    .perf_scr_o   (perf_scr_o),
    .alert_o      (alert_o)
  );
  function automatic logic [31:0] rom_fn(logic [3:0] a);
    return {a, 12'h5A5, 12'h0, a} ^ 32'h0F00_0C30;
  endfunction
  always @(posedge clk_i) rom_rdata_i <= rom_fn(rom_addr_o);
  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask
  // Checks this cycle's grants and the previous cycle's response, then records this cycle's winner.
  task automatic tick(rd_owner_e own, logic [3:0] addr, logic alert);
    sb_t e;
    @(negedge clk_i);
    e = (sb.size() > 0) ? sb.pop_front() : '{own: OwnNone, addr: 4'h0};
    check("chk_rvalid", chk_rvalid_o, e.own == OwnChk);
    check("bus_rvalid", bus_rvalid_o, e.own == OwnBus);
    check("scr_rvalid", scr_rvalid_o, e.own == OwnScr);
    if (e.own != OwnNone) check("rdata", rdata_o, rom_fn(e.addr));
    check("bus_gnt", bus_gnt_o, own == OwnBus);
    check("scr_gnt", scr_gnt_o, own == OwnScr);
    check("rom_req", rom_req_o, own != OwnNone);
    if (own != OwnNone) check("rom_addr", rom_addr_o, addr);
    check("alert", alert_o, alert);
    sb.push_back('{own: own, addr: addr});
    @(posedge clk_i);
    #1;
  endtask
  task automatic do_reset();
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("rst_rom_req", rom_req_o, 1'b0);
    check("rst_rom_addr", rom_addr_o, 4'h0);
    check("rst_alert", alert_o, 1'b0);
    check("rst_gnt", {bus_gnt_o, scr_gnt_o}, 2'b00);
    check("rst_rvalid", {chk_rvalid_o, bus_rvalid_o, scr_rvalid_o}, 3'b000);
    sb.delete();
    @(posedge clk_i);
    #1;
    check("rst_perf_stall", perf_stall_o, 16'h0);
    check("rst_perf_scr", perf_scr_o, 16'h0);
    rst_ni = 1'b1;
  endtask
  initial begin
    sel_bus_i = MuBi4False;
    {chk_req_i, bus_req_i, scr_req_i} = 3'b100;
    chk_addr_i = 4'h0;
    bus_addr_i = 4'h0;
    scr_addr_i = 4'h0;
    do_reset();
    // Checker owns the ROM; bus request is ignored
    chk_req_i = 1'b1; chk_addr_i = 4'd5; bus_req_i = 1'b1; bus_addr_i = 4'd9;
    tick(OwnChk, 4'd5, 1'b0);
    chk_req_i = 1'b0; bus_req_i = 1'b0;
    tick(OwnNone, 4'd0, 1'b0);
    // Hand-over: last checker read answers in the first Arbitrate cycle alongside a bus grant
    sel_bus_i = MuBi4True; chk_req_i = 1'b1; chk_addr_i = 4'd7;
    tick(OwnChk, 4'd7, 1'b0);
    chk_req_i = 1'b0; bus_req_i = 1'b1; bus_addr_i = 4'd2;
    tick(OwnBus, 4'd2, 1'b0);
    bus_req_i = 1'b0; scr_req_i = 1'b1; scr_addr_i = 4'd3;
    tick(OwnScr, 4'd3, 1'b0);
    // Contention: eight bus grants then one scrub grant, three rounds
    bus_req_i = 1'b1; bus_addr_i = 4'd4; scr_addr_i = 4'd11;
    for (int i = 0; i < 27; i++) tick((i % 9 == 8) ? OwnScr : OwnBus, (i % 9 == 8) ? 4'd11 : 4'd4, 1'b0);
    bus_req_i = 1'b0; scr_req_i = 1'b0;
    tick(OwnNone, 4'd0, 1'b0);
    check("perf_stall", perf_stall_o, PerfEn ? 16'd3 : 16'd0);
    check("perf_scr", perf_scr_o, PerfEn ? 16'd4 : 16'd0);
    // Checker request after hand-over is fatal
    chk_req_i = 1'b1;
    tick(OwnNone, 4'd0, 1'b0);
    chk_req_i = 1'b0; bus_req_i = 1'b1; scr_req_i = 1'b1;
    tick(OwnNone, 4'd0, 1'b1);
    tick(OwnNone, 4'd0, 1'b1);
    bus_req_i = 1'b0; scr_req_i = 1'b0; chk_req_i = 1'b1;
    do_reset();
    // In-flight checker read dropped by reset
    sel_bus_i = MuBi4False; chk_addr_i = 4'd6;
    tick(OwnChk, 4'd6, 1'b0);
    do_reset();
    chk_req_i = 1'b0;
    tick(OwnNone, 4'd0, 1'b0);
    // Invalid mubi select in CheckOwn
    sel_bus_i = 4'b0000;
    tick(OwnNone, 4'd0, 1'b0);
    sel_bus_i = MuBi4False; chk_req_i = 1'b1; bus_req_i = 1'b1;
    tick(OwnNone, 4'd0, 1'b1);
    tick(OwnNone, 4'd0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
